// File: rtl/fft_axil_pkg.sv
// Shared constants for the FFT AXI4-Lite front end: register map, STATUS/CTRL
// bit positions, AXI response codes and the handshake state type.
package fft_axil_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIN    = 2'd2;
  localparam logic [1:0] REG_DOUT   = 2'd3;

  localparam int STAT_IN_FULL       = 0;
  localparam int STAT_IN_EMPTY      = 1;
  localparam int STAT_OUT_FULL      = 2;
  localparam int STAT_OUT_EMPTY     = 3;
  localparam int STAT_CORE_BUSY     = 4;
  localparam int STAT_IN_COUNT_LSB  = 8;
  localparam int STAT_OUT_COUNT_LSB = 16;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SOFT_RST = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    AXI_IDLE,
    AXI_ACK,
    AXI_RESP
  } axi_state_e;

endpackage

// File: rtl/fft_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear; full is judged on the
// pre-pop count, so a push into a full FIFO is refused even during a pop.
module fft_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fft_axil_ctrl.sv
// AXI4-Lite register front end for the FFT core: DIN/DOUT FIFOs bridging to the
// core streams, CTRL start/soft-reset and a STATUS word of FIFO levels.
module fft_axil_ctrl
  import fft_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            core_start,
  input  logic                            core_busy,
  output logic [31:0]                     core_in_tdata,
  output logic                            core_in_tvalid,
  input  logic                            core_in_tready,
  input  logic [31:0]                     core_out_tdata,
  input  logic                            core_out_tvalid,
  output logic                            core_out_tready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  axi_state_e  wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, status, out_head;
  logic        core_start_q, core_start_d;
  logic        in_push, in_pop, in_full, in_empty;
  logic        out_push, out_pop, out_full, out_empty, fifo_clear;
  logic [CW-1:0] in_count, out_count;
  logic        unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], s00_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

  assign s00_axi_awready = (wr_state_q == AXI_ACK);
  assign s00_axi_wready  = (wr_state_q == AXI_ACK);
  assign s00_axi_bvalid  = (wr_state_q == AXI_RESP);
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = (rd_state_q == AXI_ACK);
  assign s00_axi_rvalid  = (rd_state_q == AXI_RESP);
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign core_start      = core_start_q;

  assign core_in_tvalid  = !in_empty;
  assign in_pop          = !in_empty && core_in_tready;
  assign core_out_tready = !out_full;
  assign out_push        = core_out_tvalid && !out_full;

  always_comb begin
    status = '0;
    status[STAT_IN_FULL]   = in_full;
    status[STAT_IN_EMPTY]  = in_empty;
    status[STAT_OUT_FULL]  = out_full;
    status[STAT_OUT_EMPTY] = out_empty;
    status[STAT_CORE_BUSY] = core_busy;
    status[STAT_IN_COUNT_LSB +: 8]  = 8'(in_count);
    status[STAT_OUT_COUNT_LSB +: 8] = 8'(out_count);
  end

  // Register side effects of a write all happen in its single ACK cycle.
  always_comb begin
    wr_state_d   = wr_state_q;
    bresp_d      = bresp_q;
    core_start_d = 1'b0;
    in_push      = 1'b0;
    fifo_clear   = 1'b0;
    unique case (wr_state_q)
      AXI_IDLE: if (s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) wr_state_d = AXI_ACK;
      AXI_ACK: begin
        wr_state_d = AXI_RESP;
        bresp_d    = RESP_OKAY;
        case (s00_axi_awaddr[3:2])
          REG_CTRL: if (s00_axi_wstrb[0]) begin
            core_start_d = s00_axi_wdata[CTRL_START];
            fifo_clear   = s00_axi_wdata[CTRL_SOFT_RST];
          end
          REG_DIN: begin
            in_push = 1'b1;
            if (in_full) bresp_d = RESP_SLVERR;
          end
          default: ;
        endcase
      end
      AXI_RESP: if (s00_axi_bready) wr_state_d = AXI_IDLE;
      default:  wr_state_d = AXI_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    out_pop    = 1'b0;
    unique case (rd_state_q)
      AXI_IDLE: if (s00_axi_arvalid) rd_state_d = AXI_ACK;
      AXI_ACK: begin
        rd_state_d = AXI_RESP;
        rresp_d    = RESP_OKAY;
        rdata_d    = '0;
        case (s00_axi_araddr[3:2])
          REG_STATUS: rdata_d = status;
          REG_DOUT: begin
            if (out_empty) rresp_d = RESP_SLVERR;
            else begin
              rdata_d = out_head;
              out_pop = 1'b1;
            end
          end
          default: ;
        endcase
      end
      AXI_RESP: if (s00_axi_rready) rd_state_d = AXI_IDLE;
      default:  rd_state_d = AXI_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state_q   <= AXI_IDLE;
      rd_state_q   <= AXI_IDLE;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      core_start_q <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      core_start_q <= core_start_d;
    end
  end

  fft_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk_i(s00_axi_aclk), .rst_ni(s00_axi_aresetn), .clear_i(fifo_clear),
    .push_i(in_push), .pop_i(in_pop), .data_i(s00_axi_wdata),
    .data_o(core_in_tdata), .full_o(in_full), .empty_o(in_empty), .count_o(in_count)
  );

  fft_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk_i(s00_axi_aclk), .rst_ni(s00_axi_aresetn), .clear_i(fifo_clear),
    .push_i(out_push), .pop_i(out_pop), .data_i(core_out_tdata),
    .data_o(out_head), .full_o(out_full), .empty_o(out_empty), .count_o(out_count)
  );

endmodule

// File: tb/tb_fft_axil_ctrl.sv
// Self-checking bench for fft_axil_ctrl: a queue-based model of both FIFOs and
// the register map is checked every cycle, alongside hand-computed directed results.
module tb_fft_axil_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        core_start, core_busy;
  logic [31:0] core_in_tdata, core_out_tdata;
  logic        core_in_tvalid, core_in_tready, core_out_tvalid, core_out_tready;

  int total = 0;
  int bad = 0;
  int startCount = 0;

  logic [31:0] inQ[$];
  logic [31:0] outQ[$];
  logic [33:0] expR[$];
  logic [1:0]  expB[$];
  logic        expStart = 1'b0;

  always #5 clk = ~clk;

  fft_axil_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .core_start(core_start), .core_busy(core_busy),
    .core_in_tdata(core_in_tdata), .core_in_tvalid(core_in_tvalid),
    .core_in_tready(core_in_tready), .core_out_tdata(core_out_tdata),
    .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: event seen with nothing expected", name);
  endtask

  // Model: compare against state settled by earlier edges, then apply this cycle's events.
  always @(negedge clk) begin : model
    int inPre, outPre;
    logic nextStart, doClear;
    logic [31:0] st;
    if (!rst_n) begin
      inQ.delete(); outQ.delete(); expR.delete(); expB.delete();
      expStart = 1'b0;
    end else begin
      checkOutput("in_tvalid", 64'(core_in_tvalid), 64'(inQ.size() != 0));
      checkOutput("in_tdata", 64'(core_in_tdata), 64'((inQ.size() != 0) ? inQ[0] : 32'h0));
      checkOutput("out_tready", 64'(core_out_tready), 64'(outQ.size() < DEPTH));
      checkOutput("core_start", 64'(core_start), 64'(expStart));
      if (bvalid && bready) begin
        if (expB.size() == 0) failNow("bvalid_unexpected");
        else checkOutput("bresp", 64'(bresp), 64'(expB.pop_front()));
      end
      if (rvalid && rready) begin
        if (expR.size() == 0) failNow("rvalid_unexpected");
        else checkOutput("rresp_rdata", 64'({rresp, rdata}), 64'(expR.pop_front()));
      end

      inPre = inQ.size();
      outPre = outQ.size();
      nextStart = 1'b0;
      doClear = 1'b0;
      if (inPre > 0 && core_in_tready) void'(inQ.pop_front());
      if (awvalid && wvalid && awready) begin
        case (awaddr[3:2])
          2'd0: begin
            if (wstrb[0]) begin
              nextStart = wdata[0];
              doClear = wdata[1];
            end
            expB.push_back(2'b00);
          end
          2'd2: begin
            if (inPre >= DEPTH) expB.push_back(2'b10);
            else begin
              expB.push_back(2'b00);
              inQ.push_back(wdata);
            end
          end
          default: expB.push_back(2'b00);
        endcase
      end
      if (arvalid && arready) begin
        case (araddr[3:2])
          2'd1: begin
            st = {8'h0, 8'(outPre), 8'(inPre), 3'b0, core_busy,
                  outPre == 0, outPre == DEPTH, inPre == 0, inPre == DEPTH};
            expR.push_back({2'b00, st});
          end
          2'd3: begin
            if (outPre == 0) expR.push_back({2'b10, 32'h0});
            else expR.push_back({2'b00, outQ.pop_front()});
          end
          default: expR.push_back({2'b00, 32'h0});
        endcase
      end
      if (core_out_tvalid && outPre < DEPTH) outQ.push_back(core_out_tdata);
      if (doClear) begin
        inQ.delete();
        outQ.delete();
      end
      expStart = nextStart;
    end
  end

  always @(negedge clk) if (rst_n && core_start) startCount++;

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 8);
    checkOutput("aw_latency", 64'(n), 64'(2));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    resp = 2'b11;
    do begin @(negedge clk); n++; end while (!bvalid && n < 8);
    checkOutput("b_latency", 64'(n), 64'(1));
    if (bvalid) resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axiRead(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 8);
    checkOutput("ar_latency", 64'(n), 64'(2));
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    resp = 2'b11;
    data = 32'hDEAD_BEEF;
    do begin @(negedge clk); n++; end while (!rvalid && n < 8);
    checkOutput("r_latency", 64'(n), 64'(1));
    if (rvalid) begin
      resp = rresp;
      data = rdata;
    end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      core_out_tvalid = 1'b1;
      core_out_tdata = base + 32'(i);
      @(posedge clk); #1;
    end
    core_out_tvalid = 1'b0;
    core_out_tdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    logic [1:0]  r;
    logic [31:0] d;
    int sc;
    awaddr = 4'h0; araddr = 4'h0; awprot = 3'b0; arprot = 3'b0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; bready = 1'b1;
    arvalid = 1'b0; rready = 1'b1; core_busy = 1'b0; core_in_tready = 1'b0;
    core_out_tvalid = 1'b0; core_out_tdata = 32'h0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_handshakes", 64'({awready, wready, bvalid, arready, rvalid, core_start, core_in_tvalid}), 64'(0));
    checkOutput("reset_data", 64'({bresp, rresp, rdata}), 64'(0));
    checkOutput("reset_in_tdata", 64'(core_in_tdata), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_out_tready", 64'(core_out_tready), 64'(1));
    @(posedge clk); #1;
    axiRead(4'h4, d, r);
    checkOutput("status_after_reset", 64'({r, d}), 64'({2'b00, 32'h0000_000A}));

    for (int i = 1; i <= 4; i++) begin
      axiWrite(4'h8, 32'(i), 4'hF, r);
      checkOutput("din_okay", 64'(r), 64'(2'b00));
    end
    axiRead(4'h4, d, r);
    checkOutput("status_in4", 64'(d), 64'(32'h0000_0408));
    core_in_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("drain_order", 64'({core_in_tvalid, core_in_tdata}), 64'({1'b1, 32'(i)}));
    end
    @(negedge clk);
    checkOutput("drain_done", 64'(core_in_tvalid), 64'(0));
    @(posedge clk); #1;
    core_in_tready = 1'b0;

    for (int i = 0; i < 17; i++) begin
      axiWrite(4'h8, 32'h100 + 32'(i), 4'h0, r);
      checkOutput("din_fill_resp", 64'(r), 64'((i == 16) ? 2'b10 : 2'b00));
    end
    axiRead(4'h4, d, r);
    checkOutput("status_in_full", 64'(d), 64'(32'h0000_1009));
    axiWrite(4'h0, 32'h2, 4'hF, r);
    checkOutput("soft_rst_resp", 64'(r), 64'(2'b00));
    core_busy = 1'b1;
    axiRead(4'h4, d, r);
    checkOutput("status_busy_cleared", 64'(d), 64'(32'h0000_001A));
    core_busy = 1'b0;

    applyStimulus(32'hA5A5_0001, 2);
    axiRead(4'hC, d, r);
    checkOutput("dout_first", 64'({r, d}), 64'({2'b00, 32'hA5A5_0001}));
    axiRead(4'hC, d, r);
    checkOutput("dout_second", 64'({r, d}), 64'({2'b00, 32'hA5A5_0002}));
    axiRead(4'hC, d, r);
    checkOutput("dout_empty", 64'({r, d}), 64'({2'b10, 32'h0}));

    applyStimulus(32'hB000_0000, 20);
    @(negedge clk);
    checkOutput("out_full_tready", 64'(core_out_tready), 64'(0));
    @(posedge clk); #1;
    axiRead(4'h4, d, r);
    checkOutput("status_out_full", 64'(d), 64'(32'h0010_0006));
    axiRead(4'hC, d, r);
    checkOutput("dout_after_full", 64'({r, d}), 64'({2'b00, 32'hB000_0000}));
    @(negedge clk);
    checkOutput("out_tready_back", 64'(core_out_tready), 64'(1));
    @(posedge clk); #1;

    axiWrite(4'h8, 32'h55, 4'hF, r);
    sc = startCount;
    axiWrite(4'h0, 32'h3, 4'h0, r);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ctrl_masked_start", 64'(startCount - sc), 64'(0));
    axiRead(4'h4, d, r);
    checkOutput("ctrl_masked_status", 64'(d), 64'(32'h000F_0100));
    sc = startCount;
    axiWrite(4'h0, 32'h3, 4'h1, r);
    checkOutput("ctrl_resp", 64'(r), 64'(2'b00));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("start_pulse_count", 64'(startCount - sc), 64'(1));
    axiRead(4'h4, d, r);
    checkOutput("status_after_ctrl3", 64'(d), 64'(32'h0000_000A));

    axiRead(4'h8, d, r);
    checkOutput("din_read", 64'({r, d}), 64'({2'b00, 32'h0}));
    axiWrite(4'hC, 32'hDEAD, 4'hF, r);
    checkOutput("dout_write", 64'(r), 64'(2'b00));
    axiRead(4'h0, d, r);
    checkOutput("ctrl_read", 64'({r, d}), 64'({2'b00, 32'h0}));

    axiWrite(4'h8, 32'h77, 4'hF, r);
    araddr = 4'h4;
    arvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_arready", 64'(arready), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_async", 64'({arready, rvalid, core_in_tvalid}), 64'(0));
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_rvalid", 64'(rvalid), 64'(0));
    end
    @(posedge clk); #1;
    axiRead(4'h4, d, r);
    checkOutput("status_after_abort", 64'(d), 64'(32'h0000_000A));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_axil_ctrl.md
# fft_axil_ctrl

AXI4-Lite slave front end for the FFT IP, sitting between the processor-side S00_AXI port and the FFT core's streaming input and output. Software pushes 32-bit samples through a data-in register into an input FIFO, which drains to the core over a valid/ready stream. Core results land in an output FIFO that software pops through a data-out register. A control register issues start and soft-reset, and a status register exposes FIFO levels and core busy.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; 4 registers at 0x0, 0x4, 0x8, 0xC.
- FIFO_DEPTH, 16: entries per FIFO; power of 2, from 2 to 128.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_aresetn  in  1  reset, asynchronous, active-low.
- s00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI4-Lite write channels; widths per AXI4-Lite.
- s00_axi_araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  AXI4-Lite read channels; widths per AXI4-Lite.
- core_start  out  1  one-cycle start pulse.
- core_busy  in  1  core processing flag.
- core_in_tdata  out  32  sample to core.
- core_in_tvalid  out  1  valid for core_in_tdata.
- core_in_tready  in  1  core accepts the sample.
- core_out_tdata  in  32  result from core.
- core_out_tvalid  in  1  valid for core_out_tdata.
- core_out_tready  out  1  asserted when the output FIFO is not full.

## Operation
- Register map:
  - 0x0 CTRL, write only. bit0 START pulses core_start. bit1 SOFT_RST clears both FIFOs. Both bits are self-clearing and read as 0. Both act only when wstrb[0]=1.
  - 0x4 STATUS, read only. bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty, bit4 core_busy, [15:8] in_count, [23:16] out_count, all other bits 0.
  - 0x8 DIN. A write pushes wdata into the input FIFO; wstrb is ignored. A read returns 0 with OKAY.
  - 0xC DOUT. A read pops the output FIFO head into rdata. A write is ignored with OKAY.
- Write sequence:
  - IDLE: when awvalid && wvalid && !bvalid, go to ACK.
  - ACK: awready and wready high for exactly 1 cycle; the register action happens this cycle; go to RESP.
  - RESP: bvalid held until bready, then IDLE.
- Read sequence:
  - IDLE: on arvalid, go to ACK.
  - ACK: arready high 1 cycle; rdata/rresp are captured and any DOUT pop happens this cycle; go to RESP.
  - RESP: rvalid held until rready, then IDLE.
- Read and write FSMs are independent.
- Error responses:
  - DIN write while in_full: data dropped, bresp=2'b10 (SLVERR).
  - DOUT read while out_empty: rdata=0, rresp=2'b10, no pop.
  - All other accesses respond 2'b00 (OKAY).
- Input stream: core_in_tvalid = !in_empty; core_in_tdata = input FIFO head (show-ahead). Pop on tvalid && tready.
- Output stream: core_out_tready = !out_full. Push on core_out_tvalid && core_out_tready.
- Full is evaluated before any same-cycle pop. A push into a full FIFO is refused even if a pop happens in the same cycle.
- A push into an empty FIFO in the same cycle as a pop attempt cannot happen, because pop requires not-empty.
- SOFT_RST:
  - Zeroes pointers and counts in the ACK cycle.
  - Overrides any push or pop in that cycle.
  - Does not affect AXI FSMs or the response of the write that issued it.
- Pointers wrap modulo FIFO_DEPTH. Counts use log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS.

## Timing
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, core_start 0, core_in_tdata 0, FIFOs empty.
- Because the FIFOs are empty at reset, core_in_tvalid=0 and core_out_tready=1 immediately after reset.
- Write latency: awvalid&wvalid → awready/wready on the next edge → bvalid one cycle later.
- Read latency: arvalid → arready on the next edge → rvalid one cycle later.
- core_start rises the cycle after ACK and lasts 1 cycle.
- A DIN write makes core_in_tvalid visible the cycle after ACK.
- Asserting reset mid-transaction aborts it: outputs return to reset values asynchronously, and no response is issued.

## Structure
- Package fft_axil_pkg holds:
  - register offsets REG_CTRL/REG_STATUS/REG_DIN/REG_DOUT;
  - STATUS and CTRL bit indices;
  - RESP_OKAY/RESP_SLVERR.
- Sub-module fft_sync_fifo (params WIDTH, DEPTH):
  - show-ahead FIFO with push, pop, clear, full, empty and count;
  - instantiated twice, for input and output.

## Test plan
- Reset: after reset, STATUS reads 0x0000_000A (in_empty, out_empty); all handshake outputs are 0 during reset.
- Write 0x1,0x2,0x3,0x4 to DIN with core_in_tready=0: in_count=4 and each bresp=OKAY. Then raise tready: core receives 1,2,3,4 in order, one per cycle.
- With FIFO_DEPTH=16, write 17 DIN words: the 17th gets bresp=SLVERR and in_count stays 16.
- Core returns 0xA5A5_0001, 0xA5A5_0002: DOUT reads return them in order with OKAY. A third DOUT read returns 0 with SLVERR.
- Fill the output FIFO with 16 results: core_out_tready=0 and out_full=1. One DOUT read raises core_out_tready again on the next cycle.
- Write CTRL=0x3 with both FIFOs non-empty: core_start pulses exactly 1 cycle, and STATUS then reads in_count=out_count=0.
